// File: rtl/ifetch_pkg.sv
// Shared encodings for the instruction-fetch sequencer: PC control codes and FSM states.
// S_ERR is reachable only in builds with IFETCH_TIMEOUT_EN defined.
package ifetch_pkg;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_LOAD = 2'b01;
  localparam logic [1:0] PC_INC1 = 2'b10;
  localparam logic [1:0] PC_INCN = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_HOLD = 2'b10,
    S_ERR  = 2'b11
  } ifetch_state_t;

  function automatic int tmo_cnt_width(input int tmo);
    return (tmo < 1) ? 1 : $clog2(tmo + 1);
  endfunction

endpackage

// File: rtl/ifetch_tmo_cnt.sv
// Saturating cycle counter for the mem_ack timeout; hit is high once the count reaches tmo.
module ifetch_tmo_cnt
  import ifetch_pkg::*;
#(
  parameter int tmo = 15
) (
  input  logic clk,
  input  logic clr,
  input  logic clear,
  input  logic en,
  output logic hit
);

  localparam int CW = tmo_cnt_width(tmo);

  logic [CW-1:0] cnt_reg;

  assign hit = (cnt_reg == CW'(tmo));

  always_ff @(posedge clk) begin
    if (!clr || clear) begin
      cnt_reg <= '0;
    end else if (en && !hit) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/nbit_ifetch_ctrl.sv
// Instruction-fetch sequencer: fetches the word at pc_cur, hands it to decode, steers the PC.
// Optional mem_ack timeout with sticky fetch_err is enabled by defining IFETCH_TIMEOUT_EN.
module nbit_ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int n   = 4,
  parameter int w   = 8,
  parameter int inc = 2,
  parameter int tmo = 15
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [n-1:0] pc_cur,
  output logic [1:0]   pc_ctrl,
  output logic [n-1:0] pc_load,
  output logic         mem_req,
  output logic [n-1:0] mem_addr,
  input  logic         mem_ack,
  input  logic [w-1:0] mem_data,
  output logic         ir_valid,
  output logic [w-1:0] ir_data,
  output logic [n-1:0] ir_addr,
  input  logic         ir_ready,
  input  logic         br_req,
  input  logic [n-1:0] br_target,
  output logic         fetch_err
);

  if (n < 1 || w < 1) begin : g_bad_width
    $error("nbit_ifetch_ctrl: n and w must be positive");
  end
  if (inc < 1 || tmo < 1) begin : g_bad_cfg
    $error("nbit_ifetch_ctrl: inc and tmo must be positive");
  end

  ifetch_state_t state_reg, state_next;
  logic          tmo_hit;
  logic          ir_valid_reg;
  logic [w-1:0]  ir_data_reg;
  logic [n-1:0]  ir_addr_reg;

`ifdef IFETCH_TIMEOUT_EN
  logic fetch_err_reg;

  // A branch out of S_REQ re-enters S_REQ, so it restarts the count as well.
  ifetch_tmo_cnt #(.tmo(tmo)) u_tmo_cnt (
    .clk   (clk),
    .clr   (clr),
    .clear (state_reg != S_REQ || br_req),
    .en    (state_reg == S_REQ && !mem_ack),
    .hit   (tmo_hit)
  );

  always_ff @(posedge clk) begin
    if (!clr || br_req) begin
      fetch_err_reg <= 1'b0;
    end else if (state_reg == S_REQ && tmo_hit) begin
      fetch_err_reg <= 1'b1;
    end
  end

  assign fetch_err = fetch_err_reg;
`else
  assign tmo_hit   = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (br_req) begin
      state_next = S_REQ;
    end else begin
      case (state_reg)
        S_IDLE: state_next = S_REQ;
        S_REQ: begin
`ifdef IFETCH_TIMEOUT_EN
          if (tmo_hit) state_next = S_ERR;
          else if (mem_ack) state_next = S_HOLD;
`else
          if (mem_ack) state_next = S_HOLD;
`endif
        end
        S_HOLD: if (ir_ready) state_next = S_REQ;
        default: state_next = state_reg;
      endcase
    end
  end

  // A timed-out request is withdrawn in the hit cycle; any late ack there is ignored.
  always_comb begin
    pc_ctrl  = PC_HOLD;
    mem_req  = 1'b0;
    pc_load  = br_target;
    mem_addr = pc_cur;
    if (clr) begin
      if (br_req) begin
        pc_ctrl = PC_LOAD;
      end else if (state_reg == S_REQ && !tmo_hit) begin
        mem_req = 1'b1;
        if (mem_ack) pc_ctrl = PC_INC1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      ir_valid_reg <= 1'b0;
      ir_data_reg  <= '0;
      ir_addr_reg  <= '0;
    end else if (br_req) begin
      ir_valid_reg <= 1'b0;
    end else if (state_reg == S_REQ && mem_ack && !tmo_hit) begin
      ir_valid_reg <= 1'b1;
      ir_data_reg  <= mem_data;
      ir_addr_reg  <= pc_cur;
    end else if (state_reg == S_HOLD && ir_ready) begin
      ir_valid_reg <= 1'b0;
    end
  end

  assign ir_valid = ir_valid_reg;
  assign ir_data  = ir_data_reg;
  assign ir_addr  = ir_addr_reg;

endmodule
